// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and helpers for the staged reset sequencer.
package rst_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    RESET     = 2'd0,
    RELEASE   = 2'd1,
    DONE      = 2'd2,
    SW_ASSERT = 2'd3
  } rst_seq_state_e;

  // Larger of two integers, used to size the shared cycle counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// rst_sync: asynchronous-assert, synchronous-release reset synchronizer.
// Output is low (in reset) while rst_i is high and goes high SYNC_STAGES
// clock edges after rst_i falls.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift ones into the chain once reset is removed; clear it asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_o = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// rst_seq: releases NUM_STAGES active-low domain resets one at a time,
// STAGE_CYCLES apart, after a synchronized reset deassertion. A software
// request from DONE holds every domain in reset for SW_RST_CYCLES and then
// re-runs the same release sequence.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STAGE_CYCLES  = 16,
  parameter int SW_RST_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sw_rst_req_i,
  output logic                  sw_rst_ack_o,
  output logic [NUM_STAGES-1:0] stage_rst_no,
  output logic                  seq_done_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(max_int(STAGE_CYCLES, SW_RST_CYCLES) + 1);
  localparam int IDX_W = max_int(1, $clog2(NUM_STAGES));

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1) begin : g_chk_num_stages
    $fatal(1, "rst_seq: NUM_STAGES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync_stages
    $fatal(1, "rst_seq: SYNC_STAGES must be >= 2");
  end
  if (STAGE_CYCLES < 1) begin : g_chk_stage_cycles
    $fatal(1, "rst_seq: STAGE_CYCLES must be >= 1");
  end
  if (SW_RST_CYCLES < 1) begin : g_chk_sw_rst_cycles
    $fatal(1, "rst_seq: SW_RST_CYCLES must be >= 1");
  end

  logic sync_s;

  rst_seq_state_e  state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sync_o(sync_s)
  );

  // Sequencer FSM with its counters and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= RESET;
      cnt_r        <= '0;
      idx_r        <= '0;
      stage_rst_no <= '0;
      seq_done_o   <= 1'b0;
      sw_rst_ack_o <= 1'b0;
      busy_o       <= 1'b1;
    end else begin
      sw_rst_ack_o <= 1'b0;
      case (state_r)
        RESET: begin
          if (sync_s) begin
            state_r <= RELEASE;
            cnt_r   <= '0;
            idx_r   <= '0;
          end else begin
            state_r <= RESET;
          end
        end
        RELEASE: begin
          if (cnt_r == STAGE_LAST) begin
            stage_rst_no[idx_r] <= 1'b1;
            cnt_r               <= '0;
            if (idx_r == IDX_LAST) begin
              // Last domain released: sequence complete
              state_r    <= DONE;
              idx_r      <= '0;
              seq_done_o <= 1'b1;
              busy_o     <= 1'b0;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          // Requests are only honoured here; elsewhere the level is ignored
          if (sw_rst_req_i) begin
            state_r      <= SW_ASSERT;
            stage_rst_no <= '0;
            seq_done_o   <= 1'b0;
            busy_o       <= 1'b1;
            cnt_r        <= '0;
          end else begin
            state_r <= DONE;
          end
        end
        SW_ASSERT: begin
          if (cnt_r == HOLD_LAST) begin
            state_r      <= RELEASE;
            sw_rst_ack_o <= 1'b1;
            cnt_r        <= '0;
            idx_r        <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r      <= RESET;
          cnt_r        <= '0;
          idx_r        <= '0;
          stage_rst_no <= '0;
          seq_done_o   <= 1'b0;
          busy_o       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed and randomized checks of rst_seq against a schedule
// model that derives every output from edge counts since the last anchor.
module tb_rst_seq;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int STG  = 16;
  localparam int SWC  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         ack;
  logic [N-1:0] stg;
  logic         done;
  logic         busy;

  always #5 clk = ~clk;

  rst_seq #(
    .NUM_STAGES   (N),
    .SYNC_STAGES  (SYNC),
    .STAGE_CYCLES (STG),
    .SW_RST_CYCLES(SWC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sw_rst_req_i(req),
    .sw_rst_ack_o(ack),
    .stage_rst_no(stg),
    .seq_done_o  (done),
    .busy_o      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: n counts edges since reset deassertion; anchor is the
  // edge where the release schedule starts (stage k at anchor+(k+1)*STG).
  int           n;
  int           anchor;
  int           sw_s;
  logic [N-1:0] e_stg;
  logic         e_done;
  logic         e_busy;
  logic         e_ack;

  function automatic void model_reset();
    n      = 0;
    anchor = SYNC + 1;
    sw_s   = -1;
    e_stg  = '0;
    e_done = 1'b0;
    e_busy = 1'b1;
    e_ack  = 1'b0;
  endfunction

  function automatic void model_edge(input logic req_s);
    int r;
    n = n + 1;
    if (e_done && req_s) begin
      sw_s   = n;
      anchor = n + SWC;
    end
    e_ack = (sw_s >= 0) && (n == anchor);
    if (n < anchor) r = 0;
    else r = (n - anchor) / STG;
    if (r > N) r = N;
    e_stg = '0;
    for (int i = 0; i < N; i++) if (i < r) e_stg[i] = 1'b1;
    e_done = (r == N);
    e_busy = !e_done;
  endfunction

  task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check1({tag, ".stage"}, 32'(stg), 32'(e_stg));
    check1({tag, ".done"},  32'(done), 32'(e_done));
    check1({tag, ".busy"},  32'(busy), 32'(e_busy));
    check1({tag, ".ack"},   32'(ack),  32'(e_ack));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(req);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  // Assert reset mid-cycle (no edge), check asynchronously, hold, release
  task automatic pulse_rst(input int cycles);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async");
    run(cycles);
    rst = 1'b0;
  endtask

  initial begin
    int d;
    int s;
    rst = 1'b1;
    req = 1'b0;
    model_reset();
    #1;
    check_all("por_async");
    run(5);
    rst = 1'b0;

    // Power-on sequence with an ignored request pulse during RELEASE
    run(19);
    check1("E19", 32'(stg), 32'h1);
    d = $urandom_range(1, 10);
    run(d);
    req = 1'b1;
    run(3);
    req = 1'b0;
    run(13 - d);
    check1("E35", 32'(stg), 32'h3);
    run(16);
    check1("E51", 32'(stg), 32'h7);
    run(15);
    check1("E66_done", 32'(done), 32'h0);
    run(1);
    check1("E67", 32'(stg), 32'hF);
    check1("E67_done", 32'(done), 32'h1);
    check1("E67_busy", 32'(busy), 32'h0);

    // Software request, dropped on ack
    run($urandom_range(1, 5));
    req = 1'b1;
    tick();
    s = n;
    check1("sw_S_stage", 32'(stg), 32'h0);
    run(SWC);
    check1("sw_ack", 32'(ack), 32'h1);
    check1("sw_ack_edge", 32'(n - s), 32'(SWC));
    req = 1'b0;
    run(STG);
    check1("sw_S24", 32'(stg), 32'h1);
    run(3 * STG);
    check1("sw_S72_done", 32'(done), 32'h1);
    run(6);
    check1("sw_no_repeat", 32'(done), 32'h1);

    // Request held through ack triggers a second cycle after DONE
    req = 1'b1;
    tick();
    run(SWC);
    check1("hold_ack1", 32'(ack), 32'h1);
    run(N * STG);
    check1("hold_S72_done", 32'(done), 32'h1);
    tick();
    check1("hold_S73_stage", 32'(stg), 32'h0);
    check1("hold_S73_busy", 32'(busy), 32'h1);
    run(SWC);
    check1("hold_ack2", 32'(ack), 32'h1);
    req = 1'b0;
    run(N * STG + 2);

    // Reset pulse at E40 aborts the sequence; restart has no ack
    pulse_rst(1);
    run(40);
    check1("E40_stage", 32'(stg), 32'h3);
    pulse_rst(1);
    check1("abort_stage", 32'(stg), 32'h0);
    run(67);
    check1("restart_done", 32'(done), 32'h1);

    // Randomized request levels and occasional reset pulses
    for (int it = 0; it < 20; it++) begin
      for (int c = 0; c < 150; c++) begin
        req = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 199) == 0) pulse_rst($urandom_range(1, 3));
        else tick();
      end
    end
    req = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer consuming the raw clock and reset from the clock/reset generator. It produces a set of staged, synchronously-deasserted active-low domain resets for the cluster. Domains are released one at a time at fixed cycle intervals, and a software-requested reset re-runs the same sequence. It sits directly between the clock/reset generator and the cluster's domain reset inputs.

## Interface
Parameters:
- NUM_STAGES, 4, number of staged domain resets (>= 1)
- SYNC_STAGES, 2, flops in the deassertion synchronizer (>= 2)
- STAGE_CYCLES, 16, cycles between consecutive stage releases (>= 1)
- SW_RST_CYCLES, 8, cycles all stages are held in reset on software request (>= 1)

Ports:
- clk_i  in  1  clock; one clock for the whole block
- rst_i  in  1  reset; asynchronous and active-high
- sw_rst_req_i  in  1  software reset request; level, held until ack
- sw_rst_ack_o  out  1  one-cycle pulse; hold phase finished, re-sequencing begins
- stage_rst_no  out  NUM_STAGES  per-domain active-low resets; bit 0 is released first
- seq_done_o  out  1  high while all stages are released
- busy_o  out  1  high in every state except DONE

## Operation
- States: RESET, RELEASE, DONE, SW_ASSERT.
- While rst_i is high:
  - FSM = RESET, synchronizer cleared, cnt = 0, idx = 0.
  - Output values: stage_rst_no = 0, seq_done_o = 0, sw_rst_ack_o = 0, busy_o = 1.
  - All of these apply asynchronously.
- RESET -> RELEASE: on the first edge at which the synchronizer output is sampled high. Sets cnt = 0, idx = 0.
- RELEASE counting:
  - Each edge, cnt increments.
  - At an edge with cnt == STAGE_CYCLES-1, set stage_rst_no[idx] = 1, cnt = 0, idx++.
- RELEASE -> DONE: on the edge that releases stage NUM_STAGES-1. seq_done_o rises on that same edge.
- DONE -> SW_ASSERT: at an edge with sw_rst_req_i = 1.
  - On that edge: stage_rst_no = 0, seq_done_o = 0, cnt = 0.
- SW_ASSERT -> RELEASE: at an edge with cnt == SW_RST_CYCLES-1.
  - sw_rst_ack_o = 1 for exactly one cycle; idx = 0, cnt = 0.
- sw_rst_req_i handling outside DONE:
  - The request is ignored (not latched) in RESET, RELEASE and SW_ASSERT.
  - Because it is a level, a request still high on reaching DONE is serviced then.
  - A request still high after ack triggers another reset cycle once DONE is reached again.
- Released stages stay released until rst_i or the next SW_ASSERT.
- rst_i asserting mid-sequence or mid-hold aborts immediately and asynchronously to the RESET state. No ack is generated.
- Width rules:
  - cnt width = $clog2(max(STAGE_CYCLES, SW_RST_CYCLES)+1).
  - idx width = max(1, $clog2(NUM_STAGES)).
  - Counters never wrap; they are reset at each compare match.
- Elaboration-time assertions on all parameter minimums (non-Verilator builds, $fatal).

## Timing
- Edge numbering: E1 is the first rising edge after rst_i falls.
- Synchronizer output is high after E(SYNC_STAGES). FSM enters RELEASE at E(SYNC_STAGES+1).
- Stage k releases at E(SYNC_STAGES+1+(k+1)*STAGE_CYCLES).
- seq_done_o rises together with the last stage.
- All outputs are registered; no combinational path from sw_rst_req_i to any output.
- SW request sampled at edge S:
  - Stages go low at S.
  - Ack is high during the cycle after edge S+SW_RST_CYCLES.
  - Stage k releases at S+SW_RST_CYCLES+(k+1)*STAGE_CYCLES.
- rst_i deassertion within setup/hold of clk_i is tolerated; it costs at most one extra cycle of latency.

## Structure
- rst_seq_pkg: state enum typedef rst_seq_state_e (RESET, RELEASE, DONE, SW_ASSERT).
- Sub-module rst_sync:
  - Parameterized by SYNC_STAGES.
  - Async set-to-reset when rst_i is high, synchronous release.
  - Reusable for other domain-crossing resets.
- rst_seq holds the FSM, cnt, idx and output registers.

## Test plan
- Defaults, rst_i high for 5 cycles then low:
  - stage_rst_no goes 0001 at E19, 0011 at E35, 0111 at E51, 1111 at E67.
  - seq_done_o rises at E67; busy_o falls at E67.
- Check during rst_i high: all outputs equal reset values, with no clock edge required (async check mid-cycle).
- sw_rst_req_i raised in DONE, sampled at edge S:
  - stage_rst_no = 0000 at S; sw_rst_ack_o pulses after S+8.
  - Stage 0 released at S+24; req dropped on ack; no second sequence.
- sw_rst_req_i held high through ack: a second SW_ASSERT starts at the edge after DONE is reached (S+72).
- sw_rst_req_i pulsed high for 3 cycles during RELEASE: no effect; sequence timing is unchanged.
- rst_i asserted for one cycle at E40 (stages 0,1 released):
  - All stages are 0 immediately.
  - Full sequence restarts relative to the new deassertion; no ack is produced.
